ship_heading_ctrl: RTL

//   Keyboard-to-heading front end for the ship. Decodes held PS/2 keycodes into the ship heading.

---
 rtl/astro_pkg.sv | 10 +
 rtl/heading_angle_lut.sv | 30 +++
 rtl/ship_heading_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/astro_pkg.sv
// astro_pkg: shared heading types, key codes and rotate FSM states for the ship front end
package astro_pkg;
   typedef logic [3:0] heading_t;
   localparam int NUM_HEADINGS = 16;
   localparam logic [6:0] KEY_ROT_L  = 7'h6B;
   localparam logic [6:0] KEY_ROT_R  = 7'h74;
   localparam logic [6:0] KEY_THRUST = 7'h75;
   localparam logic [6:0] KEY_FLIP   = 7'h72;
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} hdg_state_t;
endpackage

// File: rtl/heading_angle_lut.sv
// heading_angle_lut: combinational heading index -> degrees ROM (idx in, angle[8:0] out)
module heading_angle_lut
   import astro_pkg::*;
(
   input  heading_t   idx,
   output logic [8:0] angle
);
   always_comb begin
      angle = '0;
      case (idx)
         4'd0:  angle = 9'd0;
         4'd1:  angle = 9'd30;
         4'd2:  angle = 9'd45;
         4'd3:  angle = 9'd60;
         4'd4:  angle = 9'd90;
         4'd5:  angle = 9'd120;
         4'd6:  angle = 9'd135;
         4'd7:  angle = 9'd150;
         4'd8:  angle = 9'd180;
         4'd9:  angle = 9'd210;
         4'd10: angle = 9'd225;
         4'd11: angle = 9'd240;
         4'd12: angle = 9'd270;
         4'd13: angle = 9'd300;
         4'd14: angle = 9'd315;
         4'd15: angle = 9'd330;
         default: angle = 9'd0;
      endcase
   end
endmodule

// File: rtl/ship_heading_ctrl.sv
// ship_heading_ctrl: held PS/2 keycode -> ship heading with hold/auto-repeat rotation and thrust flag
//   Clk, Reset_n (async active-low), frame_tick (clock enable), keycode[7:0] in;
//   heading_idx[3:0], angle[8:0], angle_upd, thrust out. Optional 180-degree flip key: HEADING_FLIP_EN.
module ship_heading_ctrl
   import astro_pkg::*;
#(
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4,
   parameter int CNT_W        = 5
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   output heading_t   heading_idx,
   output logic [8:0] angle,
   output logic       angle_upd,
   output logic       thrust
);
   logic [6:0] code;
   logic unused_key_msb;
   logic rot_l, rot_r, rot, dir_r, dir_chg, rot_step, step;
   hdg_state_t state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   heading_t delta, nxt_idx;
   logic [8:0] nxt_angle;
   assign code = keycode[6:0];
   assign unused_key_msb = keycode[7];
   assign rot_l = code == KEY_ROT_L;
   assign rot_r = code == KEY_ROT_R;
   assign rot = rot_l | rot_r;
   assign dir_chg = rot_r != dir_r;
   always_comb begin
      nxt_state = state;
      nxt_cnt = cnt;
      rot_step = 1'b0;
      if (frame_tick)
         case (state)
            IDLE:
               if (rot) begin
                  rot_step = 1'b1;
                  nxt_cnt = '0;
                  nxt_state = HOLD;
               end
            HOLD:
               if (!rot) nxt_state = IDLE;
               else if (dir_chg || cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                  rot_step = 1'b1;
                  nxt_cnt = '0;
                  nxt_state = dir_chg ? HOLD : REPEAT;
               end else nxt_cnt = cnt + CNT_W'(1);
            REPEAT:
               if (!rot) nxt_state = IDLE;
               else if (dir_chg || cnt == CNT_W'(REPEAT_RATE - 1)) begin
                  rot_step = 1'b1;
                  nxt_cnt = '0;
                  nxt_state = dir_chg ? HOLD : REPEAT;
               end else nxt_cnt = cnt + CNT_W'(1);
            default: nxt_state = IDLE;
         endcase
   end
`ifdef HEADING_FLIP_EN
   // Flip fires once per press; re-armed only by a tick that sees the key released.
   logic flip_armed, flip_step;
   assign flip_step = frame_tick && flip_armed && code == KEY_FLIP;
   assign step = rot_step | flip_step;
   assign delta = flip_step ? 4'd8 : rot_r ? 4'hF : 4'h1;
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) flip_armed <= 1'b1;
      else if (frame_tick) flip_armed <= code != KEY_FLIP;
`else
   assign step = rot_step;
   assign delta = rot_r ? 4'hF : 4'h1;
`endif
   // 4-bit add wraps mod 16; +15 is a step right.
   assign nxt_idx = step ? heading_idx + delta : heading_idx;
   heading_angle_lut u_lut (.idx(nxt_idx), .angle(nxt_angle));
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         state <= IDLE;
         cnt <= '0;
         dir_r <= 1'b0;
         heading_idx <= '0;
         angle <= '0;
         angle_upd <= 1'b0;
         thrust <= 1'b0;
      end else begin
         thrust <= code == KEY_THRUST;
         angle_upd <= step;
         heading_idx <= nxt_idx;
         angle <= nxt_angle;
         if (frame_tick) begin
            state <= nxt_state;
            cnt <= nxt_cnt;
            if (rot) dir_r <= rot_r;
         end
      end
endmodule
